// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage.
// Contents:
//   pc_state_t : fetch-request FSM states (BOOT, ISSUE, HOLD)
//   PC_STEP    : sequential PC increment in bytes
//   JUMP_HI    : number of upper PC bits preserved on a jump
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } pc_state_t;

  localparam int unsigned PC_STEP = 32'd4;
  localparam int unsigned JUMP_HI = 32'd4;

endpackage

// File: rtl/pc_unit_sl2.sv
// sl2: shift-left-by-two stage, turns a word offset into a byte offset.
// Ports:
//   a : n-bit word offset
//   y : a << 2 (upper two bits dropped)
module sl2 #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  output logic [n-1:0] y
);

  assign y = {a[n-3:0], 2'b00};

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the single-issue datapath.
// Holds the architectural PC, offers it to instruction fetch over a
// valid/ready handshake, and forms PC+4, branch and jump targets.
// A redirect that arrives while fetch is stalled is parked in pend_pc
// so that single-cycle jump/branch pulses are never lost.
// Optional feature: define REDIRECT_CNT_EN to enable the saturating
// redirect counter; otherwise redirect_cnt is tied to zero.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pc_valid/pc   : fetch request and address (registered)
//   pc_ready      : fetch accepts pc this cycle
//   pcplus4       : pc + 4
//   branch,signimm: taken branch and its word-offset immediate
//   jump, jaddr   : jump and its 26-bit word index
//   pcbranch      : branch target pcplus4 + (signimm << 2)
//   redirect_cnt  : count of cycles with a redirect while pc_valid
module pc_unit
  import pc_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = {n{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         pc_valid,
  input  logic         pc_ready,
  output logic [n-1:0] pc,
  output logic [n-1:0] pcplus4,
  input  logic         branch,
  input  logic [n-1:0] signimm,
  input  logic         jump,
  input  logic [25:0]  jaddr,
  output logic [n-1:0] pcbranch,
  output logic [15:0]  redirect_cnt
);

  // Lowest PC bit kept from pcplus4 when forming a jump target.
  localparam int unsigned JUMP_LO = 32'd32 - JUMP_HI;

  pc_state_t    state_q, state_d;
  logic         pc_valid_q, pc_valid_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] pend_pc_q, pend_pc_d;

  logic [n-1:0] imm_sh_s;
  logic [n-1:0] jump_tgt_s;
  logic [n-1:0] redir_tgt_s;
  logic         redir_s;

  sl2 #(.n(n)) u_sl2 (
    .a (signimm),
    .y (imm_sh_s)
  );

  assign pcplus4    = pc_q + n'(PC_STEP);
  assign pcbranch   = pcplus4 + imm_sh_s;
  assign jump_tgt_s = {pcplus4[n-1:JUMP_LO], jaddr, 2'b00};
  assign redir_s    = jump | branch;

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;

  // Select the redirect target; jump outranks branch when both fire.
  always_comb begin
    redir_tgt_s = pcbranch;
    if (jump) begin
      redir_tgt_s = jump_tgt_s;
    end else begin
      redir_tgt_s = pcbranch;
    end
  end

  // Next-state logic for the fetch FSM, PC and parked redirect target.
  always_comb begin
    state_d    = state_q;
    pc_valid_d = pc_valid_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    case (state_q)
      BOOT: begin
        state_d    = ISSUE;
        pc_valid_d = 1'b1;
      end
      ISSUE: begin
        pc_valid_d = 1'b1;
        if (pc_ready) begin
          if (redir_s) begin
            pc_d = redir_tgt_s;
          end else begin
            pc_d = pcplus4;
          end
        end else if (redir_s) begin
          // Fetch is stalled: pc must stay put, so park the target.
          pend_pc_d = redir_tgt_s;
          state_d   = HOLD;
        end else begin
          state_d = ISSUE;
        end
      end
      HOLD: begin
        pc_valid_d = 1'b1;
        if (pc_ready) begin
          // A same-cycle redirect is newer than the parked one.
          if (redir_s) begin
            pc_d = redir_tgt_s;
          end else begin
            pc_d = pend_pc_q;
          end
          state_d = ISSUE;
        end else if (redir_s) begin
          pend_pc_d = redir_tgt_s;
        end else begin
          pend_pc_d = pend_pc_q;
        end
      end
      default: begin
        state_d    = BOOT;
        pc_valid_d = 1'b0;
        pc_d       = RESET_PC;
        pend_pc_d  = {n{1'b0}};
      end
    endcase
  end

  // FSM, PC and pending-target registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_valid_q <= 1'b0;
      pc_q       <= RESET_PC;
      pend_pc_q  <= {n{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_valid_q <= pc_valid_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

`ifdef REDIRECT_CNT_EN
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  // Saturating count of cycles carrying a redirect while a request is live.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    if (redir_s && pc_valid_q && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_d = redirect_cnt_q + 16'd1;
    end else begin
      redirect_cnt_d = redirect_cnt_q;
    end
  end

  // Redirect counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= 16'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
`else
  assign redirect_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        branch;
  logic [31:0] signimm;
  logic        jump;
  logic [25:0] jaddr;
  logic [31:0] pcbranch;
  logic [15:0] redirect_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference: architectural PC, whether a request is live,
  // an optional parked redirect, and the redirect count.
  logic [31:0] m_pc     = 32'h0;
  logic        m_valid  = 1'b0;
  logic        m_pend_v = 1'b0;
  logic [31:0] m_pend   = 32'h0;
  int          m_cnt    = 0;

  pc_unit #(.n(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_valid     (pc_valid),
    .pc_ready     (pc_ready),
    .pc           (pc),
    .pcplus4      (pcplus4),
    .branch       (branch),
    .signimm      (signimm),
    .jump         (jump),
    .jaddr        (jaddr),
    .pcbranch     (pcbranch),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_branch(input logic [31:0] p, input logic [31:0] imm);
    return p + 32'd4 + imm * 32'd4;
  endfunction

  function automatic logic [31:0] exp_jump(input logic [31:0] p, input logic [25:0] ja);
    logic [31:0] p4;
    p4 = p + 32'd4;
    return {p4[31:28], ja, 2'b00};
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef REDIRECT_CNT_EN
    return 16'(m_cnt);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_reset();
    m_pc     = 32'h0;
    m_valid  = 1'b0;
    m_pend_v = 1'b0;
    m_pend   = 32'h0;
    m_cnt    = 0;
  endtask

  // Advance the reference by one clock edge using the current inputs.
  task automatic model_step();
    logic [31:0] tgt;
    logic        redir;
    if (!m_valid) begin
      m_valid = 1'b1;
    end else begin
      redir = jump | branch;
      tgt   = jump ? exp_jump(m_pc, jaddr) : exp_branch(m_pc, signimm);
      if (redir && m_cnt < 65535) m_cnt++;
      if (pc_ready) begin
        if (redir)         m_pc = tgt;
        else if (m_pend_v) m_pc = m_pend;
        else               m_pc = m_pc + 32'd4;
        m_pend_v = 1'b0;
      end else if (redir) begin
        m_pend_v = 1'b1;
        m_pend   = tgt;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  // Continuous comparison of every output against the reference.
  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
    chk("pcplus4", pcplus4, m_pc + 32'd4);
    chk("pcbranch", pcbranch, exp_branch(m_pc, signimm));
    chk("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, exp_cnt()});
  end

  initial begin
    rst_n    = 1'b0;
    pc_ready = 1'b1;
    branch   = 1'b0;
    jump     = 1'b0;
    signimm  = 32'h0;
    jaddr    = 26'h0;
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'd0, pc_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from reset.
    cyc(); chk("seq0", pc, 32'h0); chk("seq_valid", {31'd0, pc_valid}, 32'h1);
    cyc(); chk("seq1", pc, 32'h4);
    cyc(); chk("seq2", pc, 32'h8);
    cyc(); chk("seq3", pc, 32'hC);

    // Jump to 0x100, then backward branch.
    jump = 1'b1; jaddr = 26'h40;
    cyc(); jump = 1'b0; chk("jump_100", pc, 32'h100);
    branch = 1'b1; signimm = 32'hFFFF_FFFE; #1;
    chk("pcbranch_fc", pcbranch, 32'h0FC);
    cyc(); branch = 1'b0; chk("branch_fc", pc, 32'h0FC);

    jump = 1'b1; jaddr = 26'h10_0000;
    cyc(); chk("jump_400000", pc, 32'h0040_0000);
    jaddr = 26'h3;
    cyc(); jump = 1'b0; chk("jump_c", pc, 32'h0000_000C);

    // Stall with a parked branch.
    jump = 1'b1; jaddr = 26'h8;
    cyc(); jump = 1'b0; chk("jump_20", pc, 32'h20);
    pc_ready = 1'b0; branch = 1'b1; signimm = 32'h4; #1;
    chk("pcbranch_34", pcbranch, 32'h34);
    cyc(); branch = 1'b0; chk("hold1", pc, 32'h20);
    cyc(); chk("hold2", pc, 32'h20);
    cyc(); chk("hold3", pc, 32'h20);
    pc_ready = 1'b1;
    cyc(); chk("release_34", pc, 32'h34);

    // Asynchronous reset while holding a parked jump.
    pc_ready = 1'b0; jump = 1'b1; jaddr = 26'h50;
    cyc(); jump = 1'b0;
    cyc();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'd0, pc_valid}, 32'h0);
    chk("async_cnt", {16'd0, redirect_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; pc_ready = 1'b1;
    cyc(); chk("reboot_pc", pc, 32'h0); chk("reboot_valid", {31'd0, pc_valid}, 32'h1);
    cyc(); chk("pend_lost", pc, 32'h4);

    // Wrap-around in both directions and jump+branch together.
    branch = 1'b1; signimm = 32'hFFFF_FFFD; #1;
    chk("pcbranch_wrap_down", pcbranch, 32'hFFFF_FFFC);
    cyc(); branch = 1'b0;
    chk("pc_fffffffc", pc, 32'hFFFF_FFFC);
    chk("pcplus4_wrap", pcplus4, 32'h0);
    jump = 1'b1; branch = 1'b1; jaddr = 26'h5; signimm = 32'h1;
    cyc(); jump = 1'b0; branch = 1'b0;
    chk("jump_wins", pc, 32'h14);
`ifdef REDIRECT_CNT_EN
    chk("cnt_two", {16'd0, redirect_cnt}, 32'h2);
`else
    chk("cnt_tied", {16'd0, redirect_cnt}, 32'h0);
`endif
    signimm = 32'h3FFF_FFFF; #1;
    chk("pcbranch_wrap_up", pcbranch, 32'h14);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      pc_ready = ($urandom_range(0, 3) != 0);
      jump     = ($urandom_range(0, 7) == 0);
      branch   = ($urandom_range(0, 3) == 0);
      jaddr    = 26'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        signimm = $urandom;
      end else begin
        logic [7:0] b;
        b = 8'($urandom);
        signimm = {{24{b[7]}}, b};
      end
      cyc();
    end
    jump = 1'b0; branch = 1'b0;
    cyc();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
